// File: rtl/maze_pkg.sv
// Types and constants shared by the maze-solver navigation blocks.
package maze_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADING,
        RAMP_UP,
        RAMP_DOWN
    } nav_state_t;

    localparam logic [11:0] HDNG_N = 12'h000;
    localparam logic [11:0] HDNG_W = 12'h3FF;
    localparam logic [11:0] HDNG_S = 12'h7FF;
    localparam logic [11:0] HDNG_E = 12'hC00;

    localparam logic [10:0] FRWRD_INC_DEF = 11'h018;
    localparam logic [10:0] MAX_FRWRD_DEF = 11'h2A0;

endpackage

// File: rtl/opn_edge_det.sv
// Registers the side-wall opening sensors and flags 0->1 transitions.
module opn_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic lft_opn,
    input  logic rght_opn,
    output logic lft_rise,
    output logic rght_rise
);

    logic [1:0] opn;
    logic [1:0] prev_reg;
    logic [1:0] rise;

    assign opn = {rght_opn, lft_opn};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_edge
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_reg[gi] <= 1'b0;
                end else begin
                    prev_reg[gi] <= opn[gi];
                end
            end

            assign rise[gi] = opn[gi] & ~prev_reg[gi];
        end
    endgenerate

    assign lft_rise  = rise[0];
    assign rght_rise = rise[1];

endmodule

// File: rtl/nav_mover.sv
// Executes heading changes and forward moves requested by the maze solver,
// ramping forward speed up and down in steps paced by gyro samples.
module nav_mover
    import maze_pkg::*;
#(
    parameter logic [10:0] FRWRD_INC = FRWRD_INC_DEF,
    parameter logic [10:0] MAX_FRWRD = MAX_FRWRD_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_hdng,
    input  logic        strt_mv,
    input  logic        stp_lft,
    input  logic        stp_rght,
    input  logic        hdng_rdy,
    input  logic        at_hdng,
    input  logic        frwrd_opn,
    input  logic        lft_opn,
    input  logic        rght_opn,
    output logic        mv_cmplt,
    output logic        moving,
    output logic        en_fusion,
    output logic [10:0] frwrd_spd
);

    nav_state_t  state_reg;
    logic [10:0] frwrd_spd_reg;
    logic        emer_reg;

    logic        lft_rise;
    logic        rght_rise;
    logic        stop_edge;
    logic [11:0] spd_sum;
    logic [10:0] spd_inc;
    logic [12:0] dec_amt;
    logic [10:0] spd_dec;

    opn_edge_det u_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .lft_opn   (lft_opn),
        .rght_opn  (rght_opn),
        .lft_rise  (lft_rise),
        .rght_rise (rght_rise)
    );

    assign stop_edge = (stp_lft & lft_rise) | (stp_rght & rght_rise);

    // Saturating step arithmetic, widened so neither direction can wrap.
    always_comb begin
        spd_sum = {1'b0, frwrd_spd_reg} + {1'b0, FRWRD_INC};
        spd_inc = (spd_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : spd_sum[10:0];
        dec_amt = emer_reg ? ({2'b00, FRWRD_INC} << 2) : ({2'b00, FRWRD_INC} << 1);
        spd_dec = ({2'b00, frwrd_spd_reg} > dec_amt)
                  ? (frwrd_spd_reg - dec_amt[10:0]) : 11'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            frwrd_spd_reg <= 11'd0;
            emer_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (strt_hdng) begin
                        state_reg <= HEADING;
                    end else if (strt_mv) begin
                        state_reg     <= RAMP_UP;
                        frwrd_spd_reg <= 11'd0;
                    end
                end
                HEADING: begin
                    frwrd_spd_reg <= 11'd0;
                    if (at_hdng && hdng_rdy) begin
                        state_reg <= IDLE;
                    end
                end
                // Leaving the ramp takes priority over a same-cycle speed step.
                RAMP_UP: begin
                    if (!frwrd_opn) begin
                        emer_reg  <= 1'b1;
                        state_reg <= RAMP_DOWN;
                    end else if (stop_edge) begin
                        state_reg <= RAMP_DOWN;
                    end else if (hdng_rdy) begin
                        frwrd_spd_reg <= spd_inc;
                    end
                end
                RAMP_DOWN: begin
                    if (frwrd_spd_reg == 11'd0) begin
                        emer_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        if (hdng_rdy) begin
                            frwrd_spd_reg <= spd_dec;
                        end
                        if (!frwrd_opn) begin
                            emer_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mv_cmplt  = ((state_reg == HEADING) && at_hdng && hdng_rdy) ||
                       ((state_reg == RAMP_DOWN) && (frwrd_spd_reg == 11'd0));
    assign moving    = (state_reg != IDLE);
    assign en_fusion = (frwrd_spd_reg > (MAX_FRWRD >> 1));
    assign frwrd_spd = frwrd_spd_reg;

endmodule

// File: tb/tb_nav_mover.sv
// Directed and random checks of nav_mover against a behavioural motion model.
module tb_nav_mover;

    localparam int INC = 24;
    localparam int MAX = 672;
    localparam int M_IDLE  = 0;
    localparam int M_TURN  = 1;
    localparam int M_ACCEL = 2;
    localparam int M_DECEL = 3;

    logic        clk;
    logic        rst_n;
    logic        strt_hdng;
    logic        strt_mv;
    logic        stp_lft;
    logic        stp_rght;
    logic        hdng_rdy;
    logic        at_hdng;
    logic        frwrd_opn;
    logic        lft_opn;
    logic        rght_opn;
    logic        mv_cmplt;
    logic        moving;
    logic        en_fusion;
    logic [10:0] frwrd_spd;

    int checks;
    int errors;

    int m_mode;
    int m_spd;
    bit m_hurry;
    bit m_prev_l;
    bit m_prev_r;
    bit prev_cmplt;

    nav_mover dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .strt_hdng (strt_hdng),
        .strt_mv   (strt_mv),
        .stp_lft   (stp_lft),
        .stp_rght  (stp_rght),
        .hdng_rdy  (hdng_rdy),
        .at_hdng   (at_hdng),
        .frwrd_opn (frwrd_opn),
        .lft_opn   (lft_opn),
        .rght_opn  (rght_opn),
        .mv_cmplt  (mv_cmplt),
        .moving    (moving),
        .en_fusion (en_fusion),
        .frwrd_spd (frwrd_spd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        m_mode     = M_IDLE;
        m_spd      = 0;
        m_hurry    = 1'b0;
        m_prev_l   = 1'b0;
        m_prev_r   = 1'b0;
        prev_cmplt = 1'b0;
    endtask

    function automatic bit model_done();
        return (m_mode == M_TURN && at_hdng && hdng_rdy) ||
               (m_mode == M_DECEL && m_spd == 0);
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit opened;
        if (!rst_n) begin
            model_reset();
        end else begin
            opened = (stp_lft && lft_opn && !m_prev_l) || (stp_rght && rght_opn && !m_prev_r);
            case (m_mode)
                M_IDLE: begin
                    if (strt_hdng) m_mode = M_TURN;
                    else if (strt_mv) begin
                        m_mode = M_ACCEL;
                        m_spd  = 0;
                    end
                end
                M_TURN: if (at_hdng && hdng_rdy) m_mode = M_IDLE;
                M_ACCEL: begin
                    if (!frwrd_opn) begin
                        m_hurry = 1'b1;
                        m_mode  = M_DECEL;
                    end else if (opened) m_mode = M_DECEL;
                    else if (hdng_rdy) m_spd = imin(m_spd + INC, MAX);
                end
                default: begin
                    if (m_spd == 0) begin
                        m_mode  = M_IDLE;
                        m_hurry = 1'b0;
                    end else begin
                        if (hdng_rdy) m_spd = imax(m_spd - (m_hurry ? 4 : 2) * INC, 0);
                        if (!frwrd_opn) m_hurry = 1'b1;
                    end
                end
            endcase
            m_prev_l = lft_opn;
            m_prev_r = rght_opn;
        end
    endtask

    task automatic tick();
        #1;
        chk("mv_cmplt", 32'(mv_cmplt), 32'(model_done()));
        chk("moving", 32'(moving), 32'(m_mode != M_IDLE));
        chk("en_fusion", 32'(en_fusion), 32'(m_spd > MAX / 2));
        chk("frwrd_spd", 32'(frwrd_spd), 32'(m_spd));
        if (mv_cmplt) chk("cmplt_single", 32'(prev_cmplt), 32'd0);
        prev_cmplt = mv_cmplt;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic pulse();
        hdng_rdy = 1'b1;
        tick();
        hdng_rdy = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        strt_hdng = 1'b0;
        strt_mv   = 1'b0;
        stp_lft   = 1'b0;
        stp_rght  = 1'b0;
        hdng_rdy  = 1'b0;
        at_hdng   = 1'b0;
        frwrd_opn = 1'b1;
        lft_opn   = 1'b0;
        rght_opn  = 1'b0;
        model_reset();

        @(negedge clk);
        chk("rst_spd", 32'(frwrd_spd), 32'd0);
        chk("rst_moving", 32'(moving), 32'd0);
        chk("rst_cmplt", 32'(mv_cmplt), 32'd0);
        chk("rst_fusion", 32'(en_fusion), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Heading change: alignment only counts together with a gyro sample.
        strt_hdng = 1'b1;
        tick();
        strt_hdng = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pulse();
            tick();
        end
        at_hdng  = 1'b1;
        hdng_rdy = 1'b1;
        #1 chk("hdng_cmplt", 32'(mv_cmplt), 32'd1);
        tick();
        hdng_rdy = 1'b0;
        at_hdng  = 1'b0;
        chk("hdng_idle", 32'(moving), 32'd0);
        chk("hdng_spd", 32'(frwrd_spd), 32'd0);

        // Ramp to saturation.
        strt_mv = 1'b1;
        tick();
        strt_mv = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            pulse();
            chk("ramp_spd", 32'(frwrd_spd), 32'(imin(INC * i, MAX)));
            chk("ramp_fusion", 32'(en_fusion), 32'(i >= 15));
            tick();
        end

        // Emergency stop from full speed.
        frwrd_opn = 1'b0;
        tick();
        for (int i = 1; i <= 7; i++) begin
            pulse();
            chk("emer_spd", 32'(frwrd_spd), 32'(imax(MAX - 4 * INC * i, 0)));
            if (i < 7) tick();
        end
        #1 chk("emer_cmplt", 32'(mv_cmplt), 32'd1);
        tick();
        frwrd_opn = 1'b1;
        chk("emer_idle", 32'(moving), 32'd0);
        tick();

        // Left-opening stop at 0x0F0.
        strt_mv = 1'b1;
        tick();
        strt_mv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pulse();
            tick();
        end
        chk("lft_start_spd", 32'(frwrd_spd), 32'h0F0);
        stp_lft = 1'b1;
        lft_opn = 1'b1;
        tick();
        for (int i = 1; i <= 5; i++) begin
            pulse();
            chk("lft_dec_spd", 32'(frwrd_spd), 32'(240 - 2 * INC * i));
            if (i < 5) tick();
        end
        #1 chk("lft_cmplt", 32'(mv_cmplt), 32'd1);
        tick();
        chk("lft_idle", 32'(moving), 32'd0);
        stp_lft = 1'b0;
        lft_opn = 1'b0;
        tick();

        // Filtering: pre-existing opening, unarmed side, late strt_hdng.
        lft_opn = 1'b1;
        tick();
        stp_lft = 1'b1;
        strt_mv = 1'b1;
        tick();
        strt_mv = 1'b0;
        pulse();
        tick();
        chk("preopen_spd", 32'(frwrd_spd), 32'd24);
        rght_opn = 1'b1;
        tick();
        pulse();
        chk("rght_unarmed_spd", 32'(frwrd_spd), 32'd48);
        strt_hdng = 1'b1;
        tick();
        strt_hdng = 1'b0;
        pulse();
        chk("hdng_ignored_spd", 32'(frwrd_spd), 32'd72);
        chk("hdng_ignored_mv", 32'(moving), 32'd1);

        // Asynchronous reset mid-ramp.
        rst_n = 1'b0;
        #1;
        chk("midrst_spd", 32'(frwrd_spd), 32'd0);
        chk("midrst_moving", 32'(moving), 32'd0);
        chk("midrst_cmplt", 32'(mv_cmplt), 32'd0);
        model_reset();
        tick();
        rst_n    = 1'b1;
        lft_opn  = 1'b0;
        rght_opn = 1'b0;
        stp_lft  = 1'b0;
        tick();

        // Both commands together: heading wins.
        strt_hdng = 1'b1;
        strt_mv   = 1'b1;
        tick();
        strt_hdng = 1'b0;
        strt_mv   = 1'b0;
        pulse();
        chk("both_spd", 32'(frwrd_spd), 32'd0);
        chk("both_moving", 32'(moving), 32'd1);
        at_hdng  = 1'b1;
        hdng_rdy = 1'b1;
        #1 chk("both_cmplt", 32'(mv_cmplt), 32'd1);
        tick();
        at_hdng  = 1'b0;
        hdng_rdy = 1'b0;
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            strt_hdng = ($urandom_range(0, 19) == 0);
            strt_mv   = ($urandom_range(0, 9) == 0);
            hdng_rdy  = ($urandom_range(0, 2) == 0);
            at_hdng   = ($urandom_range(0, 3) == 0);
            frwrd_opn = ($urandom_range(0, 39) != 0);
            stp_lft   = $urandom_range(0, 1) == 1;
            stp_rght  = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 11) == 0) lft_opn = ~lft_opn;
            if ($urandom_range(0, 11) == 0) rght_opn = ~rght_opn;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
